// File: rtl/video_effects_pkg.sv
// Shared register map, bit positions and field widths for the video effects
// control block; mirrored by the software header.
package video_effects_pkg;

    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_KEY    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_SUBST  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FRAMES = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE = 3'd7;

    localparam int unsigned CTRL_IRQ_EN_BIT     = 31;
    localparam int unsigned STATUS_PENDING_BIT  = 0;
    localparam int unsigned STATUS_IN_FRAME_BIT = 1;
    localparam int unsigned STATUS_APPLIED_BIT  = 2;
    localparam int unsigned COMMIT_BIT          = 0;

    localparam int unsigned EFFECT_W = 5;
    localparam int unsigned DELETE_W = 2;
    localparam int unsigned QUANT_W  = 2;

    // RGB565 colour layout
    localparam int unsigned RGB565_R_W = 5;
    localparam int unsigned RGB565_G_W = 6;
    localparam int unsigned RGB565_B_W = 5;
    localparam int unsigned RGB565_W   = RGB565_R_W + RGB565_G_W + RGB565_B_W;

    // One complete effect configuration (shadow or active copy)
    typedef struct packed {
        logic [RGB565_W-1:0] subst;
        logic [RGB565_W-1:0] mask;
        logic [RGB565_W-1:0] key;
        logic [QUANT_W-1:0]  quant;
        logic [DELETE_W-1:0] del;
        logic [EFFECT_W-1:0] effect;
    } effect_set_t;

endpackage

// File: rtl/video_frame_tracker.sv
// Observes the pixel stream handshake: tracks whether a frame is open and
// counts accepted start-of-packet beats.
module video_frame_tracker #(
    parameter int unsigned FRAME_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic                   ready_i,
    input  logic                   sop_i,
    input  logic                   eop_i,
    input  logic                   clear_cnt_i,
    output logic                   in_frame_o,
    output logic                   open_o,
    output logic                   frame_end_o,
    output logic [FRAME_CNT_W-1:0] count_o
);
    logic                   sop_acc, eop_acc;
    logic                   in_frame_q, in_frame_d;
    logic [FRAME_CNT_W-1:0] count_q, count_d;

    // Beat decode and next-state; eop beats sop, counter clear beats increment
    always_comb begin
        sop_acc    = valid_i & ready_i & sop_i;
        eop_acc    = valid_i & ready_i & eop_i;
        in_frame_d = in_frame_q;
        if (eop_acc) begin
            in_frame_d = 1'b0;
        end else if (sop_acc) begin
            in_frame_d = 1'b1;
        end
        count_d = count_q;
        if (clear_cnt_i) begin
            count_d = '0;
        end else if (sop_acc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Frame state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_frame_q <= 1'b0;
            count_q    <= '0;
        end else begin
            in_frame_q <= in_frame_d;
            count_q    <= count_d;
        end
    end

    // A frame is open if already inside one or it starts on this beat
    assign open_o      = in_frame_q | sop_acc;
    assign frame_end_o = open_o & eop_acc;
    assign in_frame_o  = in_frame_q;
    assign count_o     = count_q;

endmodule

// File: rtl/video_effects_ctrl.sv
// Avalon-MM control registers for the video effects pipeline. Host writes land
// in a shadow set; a commit copies it to the active outputs only between frames.
module video_effects_ctrl
    import video_effects_pkg::*;
#(
    parameter int unsigned FRAME_CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    input  logic                snoop_valid,
    input  logic                snoop_ready,
    input  logic                snoop_sop,
    input  logic                snoop_eop,
    output logic [EFFECT_W-1:0] effect,
    output logic [DELETE_W-1:0] effect_delete_rgb,
    output logic [QUANT_W-1:0]  effect_quantif_level,
    output logic [RGB565_W-1:0] effect_color_key,
    output logic [RGB565_W-1:0] effect_color_key_mask,
    output logic [RGB565_W-1:0] effect_color_substitute,
    output logic                irq
);
    effect_set_t            shadow_q, shadow_d, active_q, active_d;
    logic                   irq_en_q, irq_en_d;
    logic                   pending_q, pending_d;
    logic                   applied_q, applied_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   in_frame, frame_open, frame_end, apply;
    logic                   commit_set, applied_clr, frames_clr;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   unused_wdata;

    assign unused_wdata = ^avs_writedata[30:16];

    video_frame_tracker #(
        .FRAME_CNT_W (FRAME_CNT_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (snoop_valid),
        .ready_i     (snoop_ready),
        .sop_i       (snoop_sop),
        .eop_i       (snoop_eop),
        .clear_cnt_i (frames_clr),
        .in_frame_o  (in_frame),
        .open_o      (frame_open),
        .frame_end_o (frame_end),
        .count_o     (frame_count)
    );

    // Register writes, commit/apply handshake; apply copies the pre-edge shadow
    always_comb begin
        commit_set  = avs_write && (avs_address == ADDR_COMMIT) && avs_writedata[COMMIT_BIT];
        applied_clr = avs_write && (avs_address == ADDR_STATUS)
                      && avs_writedata[STATUS_APPLIED_BIT];
        frames_clr  = avs_write && (avs_address == ADDR_FRAMES);
        apply       = pending_q & (~frame_open | frame_end);

        shadow_d = shadow_q;
        irq_en_d = irq_en_q;
        active_d = apply ? shadow_q : active_q;
        // A fresh commit survives the apply it coincides with; set beats W1C
        pending_d = commit_set | (pending_q & ~apply);
        applied_d = apply | (applied_q & ~applied_clr);

        if (avs_write) begin
            case (avs_address)
                ADDR_CTRL: begin
                    shadow_d.effect = avs_writedata[4:0];
                    shadow_d.del    = avs_writedata[6:5];
                    shadow_d.quant  = avs_writedata[8:7];
                    irq_en_d        = avs_writedata[CTRL_IRQ_EN_BIT];
                end
                ADDR_KEY:   shadow_d.key   = avs_writedata[15:0];
                ADDR_MASK:  shadow_d.mask  = avs_writedata[15:0];
                ADDR_SUBST: shadow_d.subst = avs_writedata[15:0];
                default: ;
            endcase
        end
    end

    // Read mux; readdata holds when no read is issued
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                ADDR_CTRL: rdata_d = {irq_en_q, 22'b0, shadow_q.quant, shadow_q.del,
                                      shadow_q.effect};
                ADDR_KEY:    rdata_d[15:0] = shadow_q.key;
                ADDR_MASK:   rdata_d[15:0] = shadow_q.mask;
                ADDR_SUBST:  rdata_d[15:0] = shadow_q.subst;
                ADDR_STATUS: begin
                    rdata_d[STATUS_PENDING_BIT]  = pending_q;
                    rdata_d[STATUS_IN_FRAME_BIT] = in_frame;
                    rdata_d[STATUS_APPLIED_BIT]  = applied_q;
                end
                ADDR_FRAMES: rdata_d[FRAME_CNT_W-1:0] = frame_count;
                ADDR_ACTIVE: rdata_d[8:0] = {active_q.quant, active_q.del, active_q.effect};
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            applied_q <= applied_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_readdata            = rdata_q;
    assign effect                  = active_q.effect;
    assign effect_delete_rgb       = active_q.del;
    assign effect_quantif_level    = active_q.quant;
    assign effect_color_key        = active_q.key;
    assign effect_color_key_mask   = active_q.mask;
    assign effect_color_substitute = active_q.subst;
    assign irq                     = applied_q & irq_en_q;

endmodule

// File: tb/tb_video_effects_ctrl.sv
// Directed and randomized checks of video_effects_ctrl against a register-level
// reference model. A narrow frame counter is used so wrap-around is reachable.
module tb_video_effects_ctrl;
    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  aaddr = '0;
    logic        aw = 1'b0, ar = 1'b0;
    logic [31:0] awd = '0;
    logic [31:0] rdata;
    logic        sv = 1'b0, sr = 1'b0, ssop = 1'b0, seop = 1'b0;
    logic [4:0]  effect;
    logic [1:0]  del, quant;
    logic [15:0] key, kmask, subst;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 = ctrl bits [8:0], 1 = key, 2 = mask, 3 = subst
    logic [15:0] m_sh  [4];
    logic [15:0] m_act [4];
    bit          m_irq_en, m_pending, m_in_frame, m_applied;
    int unsigned m_count;
    logic [31:0] m_rd;

    always #5 clk = ~clk;

    video_effects_ctrl #(.FRAME_CNT_W(CW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .avs_address             (aaddr),
        .avs_write               (aw),
        .avs_writedata           (awd),
        .avs_read                (ar),
        .avs_readdata            (rdata),
        .snoop_valid             (sv),
        .snoop_ready             (sr),
        .snoop_sop               (ssop),
        .snoop_eop               (seop),
        .effect                  (effect),
        .effect_delete_rgb       (del),
        .effect_quantif_level    (quant),
        .effect_color_key        (key),
        .effect_color_key_mask   (kmask),
        .effect_color_substitute (subst),
        .irq                     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_irq_en = 0; m_pending = 0; m_in_frame = 0; m_applied = 0;
        m_count = 0; m_rd = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {m_irq_en, 22'b0, m_sh[0][8:0]};
            3'd1, 3'd2, 3'd3: return {16'b0, m_sh[a[1:0]]};
            3'd4:    return {29'b0, m_applied, m_in_frame, m_pending};
            3'd5:    return m_count;
            3'd7:    return {23'b0, m_act[0][8:0]};
            default: return 32'b0;
        endcase
    endfunction

    // One clock edge of the register-level behaviour, from pre-edge state/inputs
    task automatic model_edge();
        bit sop, eop, apply, commit, w1c;
        sop    = sv && sr && ssop;
        eop    = sv && sr && seop;
        apply  = m_pending && (!(m_in_frame || sop) || eop);
        commit = aw && aaddr == 3'd6 && awd[0];
        w1c    = aw && aaddr == 3'd4 && awd[2];
        if (ar) m_rd = model_read(aaddr);
        if (apply) m_act = m_sh;
        if (eop) m_in_frame = 0;
        else if (sop) m_in_frame = 1;
        if (sop) m_count = (m_count + 1) % (1 << CW);
        m_pending = commit || (m_pending && !apply);
        m_applied = apply || (m_applied && !w1c);
        if (aw) begin
            case (aaddr)
                3'd0: begin m_sh[0] = {7'b0, awd[8:0]}; m_irq_en = awd[31]; end
                3'd1, 3'd2, 3'd3: m_sh[aaddr[1:0]] = awd[15:0];
                3'd5: m_count = 0;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("effect",   {27'b0, effect}, {27'b0, m_act[0][4:0]});
        check("delete",   {30'b0, del},    {30'b0, m_act[0][6:5]});
        check("quant",    {30'b0, quant},  {30'b0, m_act[0][8:7]});
        check("key",      {16'b0, key},    {16'b0, m_act[1]});
        check("mask",     {16'b0, kmask},  {16'b0, m_act[2]});
        check("subst",    {16'b0, subst},  {16'b0, m_act[3]});
        check("irq",      {31'b0, irq},    {31'b0, m_applied && m_irq_en});
        check("readdata", rdata, m_rd);
    endtask

    // Inputs are driven at negedge; one edge is modelled, outputs checked at next negedge
    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        aaddr = a; awd = d; aw = 1'b1;
        step();
        aw = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        aaddr = a; ar = 1'b1;
        step();
        ar = 1'b0;
    endtask

    task automatic beat(input logic s, input logic e);
        sv = 1'b1; sr = 1'b1; ssop = s; seop = e;
        step();
        sv = 1'b0; sr = 1'b0; ssop = 1'b0; seop = 1'b0;
    endtask

    initial begin
        model_reset();
        // 1: reset state
        #1;
        check("reset_effect", {27'b0, effect}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check("reset_reg", rdata, 32'h0);
        end

        // 2: commit while idle applies on the following edge
        wr(3'd0, 32'h0000_0011);
        wr(3'd6, 32'h1);
        check("idle_not_yet", {27'b0, effect}, 32'h0);
        step();
        check("idle_applied", {27'b0, effect}, 32'h11);
        rd(3'd4);
        check("idle_status", rdata, 32'h4);

        // 3: commit during a 4-beat frame waits for the eop beat
        beat(1'b1, 1'b0);
        wr(3'd1, 32'h0000_F800);
        wr(3'd6, 32'h1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        check("frame_hold_key", {16'b0, key}, 32'h0);
        beat(1'b0, 1'b1);
        check("frame_apply_key", {16'b0, key}, 32'hF800);

        // 4: one-beat frame with commit pending
        wr(3'd5, 32'h0);
        wr(3'd2, 32'h0000_1234);
        wr(3'd6, 32'h1);
        beat(1'b1, 1'b1);
        check("onebeat_mask", {16'b0, kmask}, 32'h1234);
        rd(3'd4);
        check("onebeat_status", rdata, 32'h4);
        rd(3'd5);
        check("onebeat_frames", rdata, 32'h1);

        // 5: stalled eop does not end the frame
        beat(1'b1, 1'b0);
        wr(3'd3, 32'h0000_07E0);
        wr(3'd6, 32'h1);
        sv = 1'b1; sr = 1'b0; seop = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("stall_hold", {16'b0, subst}, 32'h0);
        sr = 1'b1;
        step();
        sv = 1'b0; sr = 1'b0; seop = 1'b0;
        check("stall_apply", {16'b0, subst}, 32'h07E0);

        // 6: frame counter wrap and clear-wins
        wr(3'd5, 32'hFFFF_FFFF);
        for (int i = 0; i < (1 << CW); i++) beat(1'b1, 1'b1);
        rd(3'd5);
        check("frames_wrap", rdata, 32'h0);
        beat(1'b1, 1'b1);
        aaddr = 3'd5; awd = 32'h0; aw = 1'b1;
        beat(1'b1, 1'b1);
        aw = 1'b0;
        rd(3'd5);
        check("frames_clear_wins", rdata, 32'h0);

        // 7: irq enable, W1C, and W1C losing to a simultaneous apply
        wr(3'd0, 32'h8000_0003);
        wr(3'd4, 32'h4);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        wr(3'd6, 32'h1);
        step();
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(3'd4, 32'h4);
        check("irq_w1c", {31'b0, irq}, 32'h0);
        wr(3'd6, 32'h1);
        wr(3'd4, 32'h4);
        check("irq_set_wins", {31'b0, irq}, 32'h1);

        // 8: asynchronous reset mid-frame with a commit pending
        beat(1'b1, 1'b0);
        wr(3'd0, 32'h0000_001F);
        wr(3'd6, 32'h1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst_async_effect", {27'b0, effect}, 32'h0);
        check("rst_async_key", {16'b0, key}, 32'h0);
        check("rst_async_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        rd(3'd4);
        check("rst_pending", rdata, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sv    = 1'($urandom_range(0, 1));
            sr    = ($urandom_range(0, 3) != 0);
            ssop  = ($urandom_range(0, 5) == 0);
            seop  = ($urandom_range(0, 5) == 0);
            aw    = ($urandom_range(0, 3) == 0);
            ar    = 1'($urandom_range(0, 1));
            aaddr = 3'($urandom_range(0, 7));
            awd   = $urandom;
            step();
        end
        aw = 1'b0; ar = 1'b0; sv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
